// File: rtl/l2_client_arbiter.sv
// Two-client round-robin front end for the unified L2: one-entry request slot per client,
// a single outstanding L2 request at a time, response routed back to the granted client.
module l2_client_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_req_valid,
    output logic                  c0_req_ready,
    input  logic [ADDR_WIDTH-1:0] c0_req_addr,
    input  logic                  c0_req_we,
    input  logic [DATA_WIDTH-1:0] c0_req_wdata,
    output logic                  c0_rsp_valid,
    input  logic                  c0_rsp_ready,
    output logic [DATA_WIDTH-1:0] c0_rsp_rdata,
    input  logic                  c1_req_valid,
    output logic                  c1_req_ready,
    input  logic [ADDR_WIDTH-1:0] c1_req_addr,
    input  logic                  c1_req_we,
    input  logic [DATA_WIDTH-1:0] c1_req_wdata,
    output logic                  c1_rsp_valid,
    input  logic                  c1_rsp_ready,
    output logic [DATA_WIDTH-1:0] c1_rsp_rdata,
    output logic                  m_req_valid,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_req_we,
    output logic [DATA_WIDTH-1:0] m_req_wdata,
    input  logic                  m_rsp_valid,
    output logic                  m_rsp_ready,
    input  logic [DATA_WIDTH-1:0] m_rsp_rdata,
    output logic [CNT_WIDTH-1:0]  c0_grant_cnt,
    output logic [CNT_WIDTH-1:0]  c1_grant_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_RSP   = 2'd2,
        CLIENT_RSP = 2'd3
    } state_t;

    state_t                state;
    logic                  gnt;
    logic                  last_gnt;
    logic                  pick;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            slot_full;
    logic [1:0]            slot_we;
    logic [ADDR_WIDTH-1:0] slot_addr  [2];
    logic [DATA_WIDTH-1:0] slot_wdata [2];
    logic [1:0]            req_acc;
    logic                  rsp_hs;
    logic                  drive_req;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // a client keeps valid (and its payload) steady until that edge.
    assign req_acc   = {c1_req_valid & ~slot_full[1], c0_req_valid & ~slot_full[0]};
    assign pick      = (&slot_full) ? ~last_gnt : slot_full[1];
    assign rsp_hs    = (state == CLIENT_RSP) && (gnt ? c1_rsp_ready : c0_rsp_ready);
    assign drive_req = (state == ISSUE) || (state == WAIT_RSP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            last_gnt      <= 1'b1;
            rsp_data      <= '0;
            slot_full     <= 2'b00;
            slot_we       <= 2'b00;
            slot_addr[0]  <= '0;
            slot_addr[1]  <= '0;
            slot_wdata[0] <= '0;
            slot_wdata[1] <= '0;
            c0_grant_cnt  <= '0;
            c1_grant_cnt  <= '0;
        end else begin
            if (req_acc[0]) begin
                slot_full[0]  <= 1'b1;
                slot_addr[0]  <= c0_req_addr;
                slot_we[0]    <= c0_req_we;
                slot_wdata[0] <= c0_req_wdata;
            end
            if (req_acc[1]) begin
                slot_full[1]  <= 1'b1;
                slot_addr[1]  <= c1_req_addr;
                slot_we[1]    <= c1_req_we;
                slot_wdata[1] <= c1_req_wdata;
            end
            case (state)
                IDLE: begin
                    if (|slot_full) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        if (pick) c1_grant_cnt <= c1_grant_cnt + CNT_WIDTH'(1);
                        else      c0_grant_cnt <= c0_grant_cnt + CNT_WIDTH'(1);
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_RSP;
                WAIT_RSP: begin
                    if (m_rsp_valid) begin
                        // Writes report zero read data regardless of what the L2 drives.
                        rsp_data <= slot_we[gnt] ? '0 : m_rsp_rdata;
                        state    <= CLIENT_RSP;
                    end
                end
                CLIENT_RSP: begin
                    if (rsp_hs) begin
                        slot_full[gnt] <= 1'b0;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end

    // The slot of the granted client cannot reload while full, so the L2 sees a stable request.
    assign m_req_valid  = (state == ISSUE);
    assign m_rsp_ready  = (state == WAIT_RSP);
    assign m_req_addr   = drive_req ? slot_addr[gnt]  : '0;
    assign m_req_we     = drive_req ? slot_we[gnt]    : 1'b0;
    assign m_req_wdata  = drive_req ? slot_wdata[gnt] : '0;

    assign c0_req_ready = ~slot_full[0];
    assign c1_req_ready = ~slot_full[1];
    assign c0_rsp_valid = (state == CLIENT_RSP) && !gnt;
    assign c1_rsp_valid = (state == CLIENT_RSP) && gnt;
    assign c0_rsp_rdata = c0_rsp_valid ? rsp_data : '0;
    assign c1_rsp_rdata = c1_rsp_valid ? rsp_data : '0;
    assign dbg_state    = state;

endmodule

// File: tb/tb_l2_client_arbiter.sv
// Directed plus randomized bench for l2_client_arbiter with a behavioural L2 and a
// per-client expected-response scoreboard.
module tb_l2_client_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid, c0_rsp_ready;
    logic [AW-1:0] c0_req_addr;
    logic [DW-1:0] c0_req_wdata, c0_rsp_rdata;
    logic          c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid, c1_rsp_ready;
    logic [AW-1:0] c1_req_addr;
    logic [DW-1:0] c1_req_wdata, c1_rsp_rdata;
    logic          m_req_valid, m_req_we, m_rsp_valid, m_rsp_ready;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata, m_rsp_rdata;
    logic [CW-1:0] c0_grant_cnt, c1_grant_cnt;
    logic [1:0]    dbg_state;

    l2_client_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
        .c0_req_we(c0_req_we), .c0_req_wdata(c0_req_wdata), .c0_rsp_valid(c0_rsp_valid),
        .c0_rsp_ready(c0_rsp_ready), .c0_rsp_rdata(c0_rsp_rdata),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
        .c1_req_we(c1_req_we), .c1_req_wdata(c1_req_wdata), .c1_rsp_valid(c1_rsp_valid),
        .c1_rsp_ready(c1_rsp_ready), .c1_rsp_rdata(c1_rsp_rdata),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wdata(m_req_wdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .c0_grant_cnt(c0_grant_cnt), .c1_grant_cnt(c1_grant_cnt),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / reference model
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] mdl_mem [logic [AW-1:0]];
    int            cnt0_exp = 0;
    int            cnt1_exp = 0;
    bit            acc0, acc1;

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic logic [AW-1:0] addr_for(input int c);
        logic [AW-1:0] r;
        r = AW'($urandom_range(0, 63)) << 2;
        return (c != 0) ? (32'h1000_0000 | r) : r;
    endfunction

    // Behavioural L2: l2_lat >= 0 fixes the WAIT_RSP stall, -1 picks 0..4 per request.
    int            l2_lat = 0;
    int            l2_wait = 0;
    bit            l2_pend = 0;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_wd;
    logic          l2_we;
    logic [DW-1:0] l2_mem [logic [AW-1:0]];

    initial begin
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                l2_pend     = 0;
                m_rsp_valid = 1'b0;
                m_rsp_rdata = '0;
            end else if (m_req_valid) begin
                l2_pend     = 1;
                l2_addr     = m_req_addr;
                l2_we       = m_req_we;
                l2_wd       = m_req_wdata;
                l2_wait     = (l2_lat < 0) ? int'($urandom_range(0, 4)) : l2_lat;
                m_rsp_valid = 1'b0;
            end else if (l2_pend && m_rsp_ready) begin
                check("l2_addr_stable", m_req_addr, l2_addr);
                check("l2_wdata_stable", m_req_wdata, l2_wd);
                if (l2_wait == 0) begin
                    m_rsp_valid = 1'b1;
                    if (l2_we) begin
                        l2_mem[l2_addr] = l2_wd;
                        m_rsp_rdata     = $urandom;
                    end else begin
                        m_rsp_rdata = l2_mem.exists(l2_addr) ? l2_mem[l2_addr] : (l2_addr ^ 32'hA5A5_5A5A);
                    end
                end else begin
                    l2_wait--;
                    m_rsp_valid = 1'b0;
                end
            end else begin
                l2_pend     = 0;
                m_rsp_valid = 1'b0;
            end
        end
    end

    // Driver: one clock cycle, scoring the handshakes that complete on this edge.
    task automatic step();
        bit            was_rst;
        bit            hold0, hold1;
        logic [DW-1:0] hd0, hd1;
        was_rst = rst;
        acc0 = !rst && c0_req_valid && c0_req_ready;
        acc1 = !rst && c1_req_valid && c1_req_ready;
        if (!rst) begin
            check("rsp_exclusive", c0_rsp_valid && c1_rsp_valid, 0);
            if (acc0) begin
                exp_q0.push_back(c0_req_we ? DW'(0) : mdl_read(c0_req_addr));
                if (c0_req_we) mdl_mem[c0_req_addr] = c0_req_wdata;
            end
            if (acc1) begin
                exp_q1.push_back(c1_req_we ? DW'(0) : mdl_read(c1_req_addr));
                if (c1_req_we) mdl_mem[c1_req_addr] = c1_req_wdata;
            end
            if (c0_rsp_valid && c0_rsp_ready) begin
                if (exp_q0.size() == 0) check("c0_rsp_unexpected", 1, 0);
                else check("c0_rsp_rdata", c0_rsp_rdata, exp_q0.pop_front());
                cnt0_exp++;
            end
            if (c1_rsp_valid && c1_rsp_ready) begin
                if (exp_q1.size() == 0) check("c1_rsp_unexpected", 1, 0);
                else check("c1_rsp_rdata", c1_rsp_rdata, exp_q1.pop_front());
                cnt1_exp++;
            end
        end
        hold0 = !rst && c0_rsp_valid && !c0_rsp_ready;
        hold1 = !rst && c1_rsp_valid && !c1_rsp_ready;
        hd0 = c0_rsp_rdata;
        hd1 = c1_rsp_rdata;
        @(posedge clk);
        #1;
        if (was_rst) begin
            exp_q0.delete();
            exp_q1.delete();
            cnt0_exp = 0;
            cnt1_exp = 0;
        end else if (!rst) begin
            if (hold0) begin
                check("c0_rsp_hold_valid", c0_rsp_valid, 1);
                check("c0_rsp_hold_rdata", c0_rsp_rdata, hd0);
            end
            if (hold1) begin
                check("c1_rsp_hold_valid", c1_rsp_valid, 1);
                check("c1_rsp_hold_rdata", c1_rsp_rdata, hd1);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        c0_rsp_ready = 1'b1;
        c1_rsp_ready = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || dbg_state != 2'd0) && n < 400) begin
            step();
            n++;
        end
        check("drain_done", (exp_q0.size() == 0) && (exp_q1.size() == 0) && (dbg_state == 2'd0), 1);
    endtask

    task automatic txn(input int c, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        int n = 0;
        if (c == 0) begin
            c0_req_addr = a; c0_req_we = we; c0_req_wdata = wd; c0_req_valid = 1'b1;
        end else begin
            c1_req_addr = a; c1_req_we = we; c1_req_wdata = wd; c1_req_valid = 1'b1;
        end
        do begin
            step();
            n++;
        end while (!((c == 0) ? acc0 : acc1) && n < 50);
        check("txn_accepted", (c == 0) ? acc0 : acc1, 1);
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
        drain();
    endtask

    task automatic check_reset(input string p);
        check({p, "_c0_req_ready"}, c0_req_ready, 1);
        check({p, "_c1_req_ready"}, c1_req_ready, 1);
        check({p, "_c0_rsp_valid"}, c0_rsp_valid, 0);
        check({p, "_c1_rsp_valid"}, c1_rsp_valid, 0);
        check({p, "_c0_rsp_rdata"}, c0_rsp_rdata, 0);
        check({p, "_c1_rsp_rdata"}, c1_rsp_rdata, 0);
        check({p, "_m_req_valid"}, m_req_valid, 0);
        check({p, "_m_req_addr"}, m_req_addr, 0);
        check({p, "_m_req_we"}, m_req_we, 0);
        check({p, "_m_req_wdata"}, m_req_wdata, 0);
        check({p, "_m_rsp_ready"}, m_rsp_ready, 0);
        check({p, "_c0_cnt"}, c0_grant_cnt, 0);
        check({p, "_c1_cnt"}, c1_grant_cnt, 0);
        check({p, "_state"}, dbg_state, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n, n0, n1;
        bit            seen;
        logic          gseq[$];
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] hd;

        c0_req_valid = 0; c0_req_addr = '0; c0_req_we = 0; c0_req_wdata = '0; c0_rsp_ready = 0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_we = 0; c1_req_wdata = '0; c1_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Single read, minimum latency
        l2_mem[32'h40]  = 32'hDEAD_BEEF;
        mdl_mem[32'h40] = 32'hDEAD_BEEF;
        c0_rsp_ready = 1'b1;
        c1_rsp_ready = 1'b1;
        c0_req_addr = 32'h40; c0_req_we = 0; c0_req_wdata = '0; c0_req_valid = 1'b1;
        step();
        c0_req_valid = 1'b0;
        check("t1_grant_no_issue", m_req_valid, 0);
        check("t1_slot_busy", c0_req_ready, 0);
        step();
        check("t1_issue", m_req_valid, 1);
        check("t1_addr", m_req_addr, 32'h40);
        check("t1_we", m_req_we, 0);
        step();
        check("t1_pulse_once", m_req_valid, 0);
        check("t1_wait", m_rsp_ready, 1);
        step();
        check("t1_rsp_valid", c0_rsp_valid, 1);
        check("t1_rdata", c0_rsp_rdata, 32'hDEAD_BEEF);
        check("t1_cnt", c0_grant_cnt, 1);
        check("t1_c1_quiet", c1_rsp_valid, 0);
        step();
        check("t1_slot_free", c0_req_ready, 1);
        check("t1_rsp_done", c0_rsp_valid, 0);

        // Both clients right after reset, continuously requesting two each
        rst = 1'b1;
        step();
        rst = 1'b0;
        l2_lat = -1;
        n0 = 0; n1 = 0; n = 0;
        c0_req_addr = addr_for(0); c0_req_we = 0;
        c1_req_addr = addr_for(1); c1_req_we = 0;
        while (gseq.size() < 4 && n < 300) begin
            c0_req_valid = (n0 < 2);
            c1_req_valid = (n1 < 2);
            step();
            n++;
            if (acc0) begin n0++; c0_req_addr = addr_for(0); end
            if (acc1) begin n1++; c1_req_addr = addr_for(1); end
            if (m_req_valid) gseq.push_back(m_req_addr[28]);
        end
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
        drain();
        check("t2_grants", gseq.size(), 4);
        for (int i = 0; i < gseq.size(); i++) check($sformatf("t2_order%0d", i), gseq[i], i % 2);
        check("t2_c0_cnt", c0_grant_cnt, 2);
        check("t2_c1_cnt", c1_grant_cnt, 2);

        // Client 1 write with a 20-cycle L2 stall
        l2_lat = 20;
        c1_req_addr = 32'h100; c1_req_we = 1; c1_req_wdata = 32'h1234_5678; c1_req_valid = 1'b1;
        step();
        c1_req_valid = 1'b0;
        n = 0;
        while (!m_req_valid && n < 10) begin step(); n++; end
        check("t3_issue_seen", m_req_valid, 1);
        step();
        n = 0;
        while (m_rsp_ready && n < 50) begin
            check("t3_addr_stable", m_req_addr, 32'h100);
            check("t3_wdata_stable", m_req_wdata, 32'h1234_5678);
            check("t3_we_stable", m_req_we, 1);
            n++;
            step();
        end
        check("t3_wait_cycles", n, 21);
        check("t3_rsp_valid", c1_rsp_valid, 1);
        check("t3_rdata_zero", c1_rsp_rdata, 0);
        drain();

        // Response backpressure on client 0 while client 1 gets queued
        l2_lat = 0;
        a0 = addr_for(0);
        c0_rsp_ready = 1'b0;
        c0_req_addr = a0; c0_req_we = 0; c0_req_valid = 1'b1;
        step();
        c0_req_valid = 1'b0;
        n = 0;
        while (!c0_rsp_valid && n < 20) begin step(); n++; end
        check("t4_rsp_seen", c0_rsp_valid, 1);
        hd = c0_rsp_rdata;
        check("t4_rdata", hd, mdl_read(a0));
        a1 = addr_for(1);
        c1_req_addr = a1; c1_req_we = 0; c1_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", c0_rsp_valid, 1);
            check("t4_hold_rdata", c0_rsp_rdata, hd);
            check("t4_c0_busy", c0_req_ready, 0);
            check("t4_no_issue", m_req_valid, 0);
            step();
            if (acc1) c1_req_valid = 1'b0;
        end
        check("t4_c1_accepted", c1_req_ready, 0);
        c0_rsp_ready = 1'b1;
        step();
        check("t4_idle_after_hs", dbg_state, 0);
        check("t4_no_early_issue", m_req_valid, 0);
        step();
        check("t4_c1_issue", m_req_valid, 1);
        check("t4_c1_addr", m_req_addr, a1);
        drain();

        // Reset during WAIT_RSP
        l2_lat = 10;
        c0_req_addr = addr_for(0); c0_req_we = 0; c0_req_valid = 1'b1;
        step();
        c0_req_valid = 1'b0;
        n = 0;
        while (!m_rsp_ready && n < 20) begin step(); n++; end
        check("t5_in_wait", m_rsp_ready, 1);
        step();
        rst = 1'b1;
        step();
        check_reset("t5");
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            step();
            if (c0_rsp_valid || c1_rsp_valid) seen = 1;
        end
        check("t5_no_rsp", seen, 0);

        // Grant counter wrap
        l2_lat = -1;
        for (int i = 0; i < (1 << CW) - 1; i++) txn(0, addr_for(0), 1'b0, '0);
        check("t6_cnt_max", c0_grant_cnt, (1 << CW) - 1);
        txn(0, addr_for(0), 1'b0, '0);
        check("t6_cnt_wrap", c0_grant_cnt, 0);
        check("t6_c1_cnt", c1_grant_cnt, 0);

        // Randomized traffic from both clients
        for (int i = 0; i < 400; i++) begin
            if (!c0_req_valid || acc0) begin
                c0_req_valid = 1'($urandom_range(0, 1));
                c0_req_we    = 1'($urandom_range(0, 1));
                c0_req_addr  = addr_for(0);
                c0_req_wdata = $urandom;
            end
            if (!c1_req_valid || acc1) begin
                c1_req_valid = 1'($urandom_range(0, 1));
                c1_req_we    = 1'($urandom_range(0, 1));
                c1_req_addr  = addr_for(1);
                c1_req_wdata = $urandom;
            end
            c0_rsp_ready = ($urandom_range(0, 3) != 0);
            c1_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
        drain();
        check("rand_c0_cnt", c0_grant_cnt, cnt0_exp % (1 << CW));
        check("rand_c1_cnt", c1_grant_cnt, cnt1_exp % (1 << CW));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
